// File: rtl/dma_rd_arb_pkg.sv
// dma_rd_arb_pkg: command type and round-robin pick helper shared by the dma_rd arbiter
package dma_rd_arb_pkg;
    localparam int CMD_ADDR_W = 32;
    localparam int CMD_LEN_W  = 9;
    localparam int MAX_REQ    = 32;
    typedef struct packed {
        logic [CMD_ADDR_W-1:0] addr;
        logic [CMD_LEN_W-1:0]  len;
    } cmd_t;
    typedef struct packed {
        logic               any;
        logic [MAX_REQ-1:0] grant;
        logic [4:0]         idx;
    } pick_t;
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid, input int unsigned n, input int unsigned ptr);
        pick_t p;
        int unsigned i;
        p = '0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            i = (ptr + k) % n;
            if (k < n && !p.any && valid[i]) begin
                p.any      = 1'b1;
                p.grant[i] = 1'b1;
                p.idx      = 5'(i);
            end
        end
        return p;
    endfunction
endpackage

// File: rtl/dma_rd_arb_tagq.sv
// dma_rd_arb_tagq: FIFO of requester tags that own the transfers outstanding in dma_rd
module dma_rd_arb_tagq #(
    parameter int ID_WIDTH = 2,
    parameter int DEPTH    = 3,
    localparam int CW      = $clog2(DEPTH + 1),
    localparam int PW      = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  logic                pop,
    input  logic [ID_WIDTH-1:0] push_id,
    output logic [ID_WIDTH-1:0] head,
    output logic [CW-1:0]       count,
    output logic                full,
    output logic                empty
);
    logic [ID_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_id;
                wr_ptr      <= inc(wr_ptr);
            end
            if (pop) rd_ptr <= inc(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end
    assign head  = mem[rd_ptr];
    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;
endmodule

// File: rtl/dma_rd_arb.sv
// dma_rd_arb: round-robin command arbiter and tag-routed stream demux in front of one dma_rd engine.
// Define DMA_RD_ARB_STATS_EN to add per-requester routed-beat counters on beat_count.
module dma_rd_arb
    import dma_rd_arb_pkg::*;
#(
    parameter int NUM_REQ           = 4,
    parameter int AXI_ADDR_WIDTH    = CMD_ADDR_W,
    parameter int AXI_DATA_WIDTH    = 32,
    parameter int CONFIG_LEN_WIDTH  = CMD_LEN_W,
    parameter int OUTSTANDING_COUNT = 2,
    localparam int ID_WIDTH         = $clog2(NUM_REQ)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*CONFIG_LEN_WIDTH-1:0] req_len,
    output logic                               config_valid,
    input  logic                               config_ready,
    output logic [AXI_ADDR_WIDTH-1:0]          config_addr,
    output logic [CONFIG_LEN_WIDTH-1:0]        config_len,
    input  logic                               config_empty,
    input  logic [AXI_DATA_WIDTH-1:0]          s_data,
    input  logic                               s_valid,
    input  logic                               s_last,
    output logic                               s_ready,
    output logic [AXI_DATA_WIDTH-1:0]          m_data,
    output logic [NUM_REQ-1:0]                 m_valid,
    output logic [NUM_REQ-1:0]                 m_last,
    input  logic [NUM_REQ-1:0]                 m_ready,
    output logic                               idle
`ifdef DMA_RD_ARB_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]              beat_count
`endif
);
    localparam int DEPTH = OUTSTANDING_COUNT + 1;
    localparam int CW    = $clog2(DEPTH + 1);
    cmd_t cmd_q;
    pick_t pick;
    logic cmd_vld, tag_full, tag_empty, fire, hs, pop, loadable, accept, load;
    logic [ID_WIDTH-1:0] ptr, head, win;
    logic [CW-1:0] tag_count;
    logic [CONFIG_LEN_WIDTH-1:0] win_len;
    logic [NUM_REQ-1:0] head_one;
    assign pick     = rr_pick(MAX_REQ'(req_valid), NUM_REQ, 32'(ptr));
    assign win      = ID_WIDTH'(pick.idx);
    assign win_len  = req_len[win*CONFIG_LEN_WIDTH +: CONFIG_LEN_WIDTH];
    assign fire     = config_valid && config_ready;
    assign hs       = s_valid && s_ready;
    assign pop      = hs && s_last;
    // a tag freed by this cycle's last beat can be reused by this cycle's load
    assign loadable = rst_n && (!cmd_vld || fire) && (!tag_full || pop);
    assign accept   = loadable && pick.any;
    // zero-length commands never produce a stream, so they are acknowledged but not issued
    assign load     = accept && win_len != '0;
    assign req_ready = accept ? NUM_REQ'(pick.grant) : '0;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_vld <= 1'b0;
            cmd_q   <= '0;
            ptr     <= '0;
        end else begin
            if (load) begin
                cmd_vld <= 1'b1;
                cmd_q   <= '{addr: req_addr[win*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH], len: win_len};
            end else if (fire) begin
                cmd_vld <= 1'b0;
            end
            if (accept) ptr <= (win == ID_WIDTH'(NUM_REQ - 1)) ? '0 : win + 1'b1;
        end
    end
    dma_rd_arb_tagq #(.ID_WIDTH(ID_WIDTH), .DEPTH(DEPTH)) u_tagq (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (load),
        .pop     (pop),
        .push_id (win),
        .head    (head),
        .count   (tag_count),
        .full    (tag_full),
        .empty   (tag_empty)
    );
    assign config_valid = cmd_vld;
    assign config_addr  = cmd_q.addr;
    assign config_len   = cmd_q.len;
    assign head_one     = NUM_REQ'(1) << head;
    assign m_data       = s_data;
    assign m_valid      = (s_valid && !tag_empty) ? head_one : '0;
    assign m_last       = (s_valid && s_last && !tag_empty) ? head_one : '0;
    assign s_ready      = !tag_empty && m_ready[head];
    assign idle         = !cmd_vld && tag_count == '0 && config_empty && req_valid == '0;
`ifdef DMA_RD_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) beat_count <= '0;
        else if (hs) beat_count[head*32 +: 32] <= beat_count[head*32 +: 32] + 32'd1;
    end
`endif
endmodule

// File: tb/tb_dma_rd_arb.sv
// tb_dma_rd_arb: directed and randomized checks of dma_rd_arb against a queue-based reference
module tb_dma_rd_arb;
    localparam int N = 4, AW = 32, DW = 32, LW = 9, DEPTH = 3;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [N-1:0] req_valid, req_ready, m_valid, m_last, m_ready;
    logic [N*AW-1:0] req_addr;
    logic [N*LW-1:0] req_len;
    logic config_valid, config_ready, config_empty, s_valid, s_last, s_ready, idle;
    logic [AW-1:0] config_addr;
    logic [LW-1:0] config_len;
    logic [DW-1:0] s_data, m_data;

    dma_rd_arb dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_len(req_len), .config_valid(config_valid),
        .config_ready(config_ready), .config_addr(config_addr), .config_len(config_len),
        .config_empty(config_empty), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .m_data(m_data), .m_valid(m_valid), .m_last(m_last),
        .m_ready(m_ready), .idle(idle)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    logic [AW-1:0] r_addr [N];
    logic [LW-1:0] r_len [N];
    bit r_pend [N];
    int unsigned cr_pct = 100, sv_pct = 100, mr_pct = 100, refill_pct = 0;
    int min_len = 1, max_len = 4;
    int src_q[$];
    logic [DW-1:0] beat_data = 32'hA5A5_0001;
    int m_ptr = 0;
    bit m_cmd_v = 0;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_len;
    int m_tags[$];
    int grant_log[$], route_log[$];
    logic [N-1:0] obs_rready;
    logic obs_sready, obs_cfgv, obs_idle;
    logic [DW-1:0] obs_mdata;
    logic [AW-1:0] obs_caddr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic new_cmd(input int i);
        r_addr[i] = $urandom;
        r_len[i]  = LW'($urandom_range(max_len, min_len));
        r_pend[i] = 1;
    endtask

    function automatic bit model_idle();
        bit any = 0;
        for (int i = 0; i < N; i++) any |= r_pend[i];
        return !m_cmd_v && m_tags.size() == 0 && src_q.size() == 0 && !any;
    endfunction

    // One clock: drive stimulus, compare against the reference, advance reference and stimulus state.
    task automatic cycle();
        int head, win;
        bit pop, fire, rdy, e_idle;
        logic [N-1:0] e_rready, e_mvalid, e_mlast;
        for (int i = 0; i < N; i++) begin
            req_valid[i] = r_pend[i];
            req_addr[i*AW +: AW] = r_addr[i];
            req_len[i*LW +: LW] = r_len[i];
            m_ready[i] = $urandom_range(99) < mr_pct;
        end
        config_ready = $urandom_range(99) < cr_pct;
        config_empty = src_q.size() == 0;
        s_valid = src_q.size() > 0 && $urandom_range(99) < sv_pct;
        s_last = src_q.size() > 0 && src_q[0] == 1;
        s_data = beat_data;
        #2;
        head = m_tags.size() > 0 ? m_tags[0] : 0;
        rdy = m_tags.size() > 0 && m_ready[head];
        e_mvalid = (s_valid && m_tags.size() > 0) ? N'(1) << head : '0;
        e_mlast = s_last ? e_mvalid : '0;
        pop = s_valid && rdy && s_last;
        fire = m_cmd_v && config_ready;
        win = -1;
        if ((!m_cmd_v || fire) && m_tags.size() - int'(pop) < DEPTH)
            for (int k = 0; k < N; k++)
                if (win < 0 && r_pend[(m_ptr + k) % N]) win = (m_ptr + k) % N;
        e_rready = win >= 0 ? N'(1) << win : '0;
        e_idle = !m_cmd_v && m_tags.size() == 0 && src_q.size() == 0 && req_valid == '0;
        chk("req_ready", 64'(req_ready), 64'(e_rready));
        chk("config_valid", 64'(config_valid), 64'(m_cmd_v));
        if (m_cmd_v) begin
            chk("config_addr", 64'(config_addr), 64'(m_addr));
            chk("config_len", 64'(config_len), 64'(m_len));
        end
        chk("m_valid", 64'(m_valid), 64'(e_mvalid));
        chk("m_last", 64'(m_last), 64'(e_mlast));
        chk("s_ready", 64'(s_ready), 64'(rdy));
        chk("idle", 64'(idle), 64'(e_idle));
        chk("m_data", 64'(m_data), 64'(s_data));
        obs_rready = req_ready; obs_sready = s_ready; obs_mdata = m_data;
        obs_cfgv = config_valid; obs_caddr = config_addr; obs_idle = idle;
        if (s_valid && rdy) begin
            route_log.push_back(head);
            beat_data = $urandom;
            if (src_q[0] == 1) void'(src_q.pop_front());
            else src_q[0] = src_q[0] - 1;
        end
        if (pop) void'(m_tags.pop_front());
        if (fire) begin
            m_cmd_v = 0;
            src_q.push_back(int'(m_len));
        end
        if (win >= 0) begin
            grant_log.push_back(win);
            m_ptr = (win + 1) % N;
            if (r_len[win] != 0) begin
                m_cmd_v = 1; m_addr = r_addr[win]; m_len = r_len[win];
                m_tags.push_back(win);
            end
            r_pend[win] = 0;
        end
        for (int i = 0; i < N; i++)
            if (!r_pend[i] && $urandom_range(99) < refill_pct) new_cmd(i);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n = 0;
        refill_pct = 0; cr_pct = 100; sv_pct = 100; mr_pct = 100;
        while (!model_idle() && n < 300) begin cycle(); n++; end
        chk("drain_done", 64'(model_idle()), 64'(1));
        cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int exp_order[5];
        logic [DW-1:0] held;
        logic [AW-1:0] hold_addr;
        exp_order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < N; i++) begin r_pend[i] = 0; r_addr[i] = '0; r_len[i] = '0; end
        req_valid = '0; req_addr = '0; req_len = '0; m_ready = '0;
        config_ready = 0; config_empty = 1; s_valid = 0; s_last = 0; s_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_config_valid", 64'(config_valid), 64'(0));
        chk("rst_config_addr", 64'(config_addr), 64'(0));
        chk("rst_config_len", 64'(config_len), 64'(0));
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_m_valid", 64'(m_valid), 64'(0));
        chk("rst_s_ready", 64'(s_ready), 64'(0));
        chk("rst_idle", 64'(idle), 64'(1));
        rst_n = 1;

        // fairness: everyone always valid with 1-beat commands
        min_len = 1; max_len = 1; refill_pct = 100;
        for (int i = 0; i < N; i++) new_cmd(i);
        n = 0;
        while (grant_log.size() < 5 && n < 50) begin cycle(); n++; end
        chk("fair_grants", 64'(grant_log.size() >= 5), 64'(1));
        drain();
        for (int i = 0; i < 5; i++) begin
            chk("fair_grant_order", 64'(grant_log[i]), 64'(exp_order[i]));
            chk("fair_route_order", 64'(route_log[i]), 64'(exp_order[i]));
        end

        // single request from requester 2
        grant_log.delete(); route_log.delete();
        r_addr[2] = 32'h1000; r_len[2] = 9'd4; r_pend[2] = 1;
        cycle();
        chk("single_grant", 64'(obs_rready), 64'(4'b0100));
        chk("single_config", 64'({config_valid, config_addr, config_len}), 64'({1'b1, 32'h1000, 9'd4}));
        drain();
        chk("single_beats", 64'(route_log.size()), 64'(4));
        foreach (route_log[i]) chk("single_route", 64'(route_log[i]), 64'(2));

        // config backpressure, then tag FIFO full with no stream returned
        grant_log.delete();
        for (int i = 0; i < N; i++) begin r_addr[i] = $urandom; r_len[i] = 9'd2; r_pend[i] = 1; end
        cr_pct = 0; sv_pct = 0;
        cycle();
        hold_addr = r_addr[grant_log[0]];
        repeat (5) begin
            cycle();
            chk("bp_cfg_valid", 64'(obs_cfgv), 64'(1));
            chk("bp_cfg_addr", 64'(obs_caddr), 64'(hold_addr));
            chk("bp_req_ready", 64'(obs_rready), 64'(0));
        end
        cr_pct = 100;
        repeat (6) cycle();
        repeat (3) begin
            cycle();
            chk("full_req_ready", 64'(obs_rready), 64'(0));
        end
        chk("full_grants", 64'(grant_log.size()), 64'(3));
        drain();

        // per-requester stall in the middle of a stream
        route_log.delete();
        r_addr[3] = $urandom; r_len[3] = 9'd6; r_pend[3] = 1;
        n = 0;
        while (route_log.size() < 2 && n < 20) begin cycle(); n++; end
        chk("stall_start", 64'(route_log.size()), 64'(2));
        held = beat_data;
        mr_pct = 0;
        repeat (3) begin
            cycle();
            chk("stall_s_ready", 64'(obs_sready), 64'(0));
            chk("stall_m_data", 64'(obs_mdata), 64'(held));
        end
        drain();
        chk("stall_beats", 64'(route_log.size()), 64'(6));

        // zero-length command from requester 1
        r_addr[1] = $urandom; r_len[1] = 9'd0; r_pend[1] = 1;
        cycle();
        chk("zero_req_ready", 64'(obs_rready), 64'(4'b0010));
        cycle();
        chk("zero_no_config", 64'(obs_cfgv), 64'(0));
        chk("zero_idle", 64'(obs_idle), 64'(1));
        for (int i = 1; i < N; i++) begin r_addr[i] = $urandom; r_len[i] = 9'd1; r_pend[i] = 1; end
        cycle();
        chk("zero_ptr_next", 64'(obs_rready), 64'(4'b0100));
        drain();

        // randomized traffic
        min_len = 0; max_len = 4; refill_pct = 30;
        cr_pct = 70; sv_pct = 70; mr_pct = 70;
        repeat (1500) cycle();
        drain();

        // synchronous reset in the middle of a stream
        route_log.delete();
        r_addr[0] = $urandom; r_len[0] = 9'd8; r_pend[0] = 1;
        n = 0;
        while (route_log.size() < 3 && n < 20) begin cycle(); n++; end
        chk("rst_mid_started", 64'(route_log.size()), 64'(3));
        rst_n = 0; req_valid = '0; s_valid = 1; s_last = 0; m_ready = '1; config_empty = 1;
        for (int i = 0; i < N; i++) r_pend[i] = 0;
        src_q.delete(); m_tags.delete(); m_cmd_v = 0; m_ptr = 0;
        @(posedge clk); #1;
        chk("rst_mid_config_valid", 64'(config_valid), 64'(0));
        chk("rst_mid_m_valid", 64'(m_valid), 64'(0));
        chk("rst_mid_s_ready", 64'(s_ready), 64'(0));
        chk("rst_mid_idle", 64'(idle), 64'(1));
        rst_n = 1;
        r_addr[1] = $urandom; r_len[1] = 9'd2; r_pend[1] = 1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
